// File: rtl/spi_pkg.sv
// Shared SPI constants: 2-bit frame state encoding (common with the master FSM) and default word width.
// Declarations only; no latency or backpressure.
package spi_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous level, plus single-cycle rise/fall strobes.
// Strobes appear STAGES+1 clk edges after the input changes; no backpressure.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              d_sync;

    assign d_sync = sync_q[STAGES-1];

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        prev_d = d_sync;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = d_sync & ~prev_q;
    assign fall = ~d_sync & prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave without chip select: oversamples sck/mosi, receives one MSB-first word per frame, returns a preloaded word on miso.
// rx_valid lands SYNC_STAGES+2 clk after the last sck rise; tx_load is accepted only while tx_ready (IDLE).
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic sck_rise, sck_fall;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // Same depth as the sck path so the sample taken on rise is the bit the master set up.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_next;
    logic [CNT_W-1:0]  bit_cnt_inc;
    logic              frame_done;
    logic              idle_expired;

    always_comb begin
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        rx_next      = (rx_shift_q << 1) | DATA_W'(mosi_s);
        tx_next      = tx_shift_q << 1;
        bit_cnt_inc  = bit_cnt_q + CNT_W'(1);
        frame_done   = (bit_cnt_inc == CNT_W'(DATA_W));
        idle_expired = (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                // The first rise opens the frame, so a coincident tx_load loses.
                if (sck_rise) begin
                    rx_shift_d = rx_next;
                    if (frame_done) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        tx_shift_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_inc;
                        state_d   = ST_SHIFT;
                    end
                end else if (tx_load) begin
                    tx_shift_d = tx_data;
                end
            end

            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_shift_d = rx_next;
                    idle_cnt_d = '0;
                    if (frame_done) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        tx_shift_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_inc;
                    end
                end else if (sck_fall) begin
                    tx_shift_d = tx_next;
                    idle_cnt_d = '0;
                end else if (idle_expired) begin
                    // Partial frame dropped; tx_shift keeps whatever was not yet shifted out.
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    idle_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end

            default: begin
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = tx_shift_q[DATA_W-1];
    assign tx_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: the bench plays the SPI master and predicts each frame from word-level rules.
module tb_spi_slave_rx_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 32;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          sck     = 1'b0;
    logic          mosi    = 1'b0;
    logic          tx_load = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso, tx_ready, rx_valid, frame_err, busy;
    logic [DW-1:0] rx_data;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;

    // Word-level model: what the master will read back, and the last word delivered.
    logic [DW-1:0] exp_tx = '0;
    logic [DW-1:0] exp_rx = '0;

    always #5 clk = ~clk;

    spi_slave_rx_tx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (rx_valid)  rv_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_tx(input logic [DW-1:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        exp_tx  = v;
    endtask

    // Master side of one frame: mosi changes with each fall, miso is read just before each rise.
    // The low phase before bit gap_bit lasts gap_len cycles; a tx_load of load_val is attempted before bit load_bit.
    task automatic run_frame(input logic [DW-1:0] w, input int nbits, input int hp,
                             input int gap_bit, input int gap_len,
                             input int load_bit, input logic [DW-1:0] load_val,
                             output logic [DW-1:0] got);
        int lo;
        got = '0;
        @(negedge clk);
        mosi = w[DW-1];
        for (int i = 0; i < nbits; i++) begin
            lo = (i == gap_bit) ? gap_len : hp;
            if (i == load_bit) begin
                @(negedge clk);
                tx_data = load_val;
                tx_load = 1'b1;
                check_eq("tx_ready_in_shift", tx_ready, 0);
                check_eq("busy_in_shift", busy, 1);
                @(negedge clk);
                tx_load = 1'b0;
                lo = lo - 2;
            end
            repeat (lo) @(negedge clk);
            got = {got[DW-2:0], miso};
            sck = 1'b1;
            repeat (hp) @(negedge clk);
            sck = 1'b0;
            if (i + 1 < nbits) mosi = w[DW-2-i];
        end
    endtask

    task automatic full_frame(input string tag, input logic [DW-1:0] w, input int hp, input int gap_len,
                              input int load_bit, input logic [DW-1:0] load_val);
        int            rv0, fe0;
        logic [DW-1:0] got;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        run_frame(w, DW, hp, 3, gap_len, load_bit, load_val, got);
        repeat (SS + 4) @(negedge clk);
        check_eq({tag, "_master_rx"}, got, exp_tx);
        check_eq({tag, "_rx_data"}, rx_data, w);
        check_eq({tag, "_rx_valid_pulses"}, rv_cnt - rv0, 1);
        check_eq({tag, "_frame_err_pulses"}, fe_cnt - fe0, (gap_len > TO) ? 1 : 0);
        check_eq({tag, "_busy_after"}, busy, 0);
        check_eq({tag, "_tx_ready_after"}, tx_ready, 1);
        check_eq({tag, "_miso_after"}, miso, 0);
        exp_tx = '0;
        exp_rx = w;
    endtask

    initial begin
        logic [DW-1:0] got, w;
        int            rv0, fe0, hp;

        repeat (3) @(negedge clk);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        load_tx(8'h3C);
        repeat (2) @(negedge clk);
        check_eq("load_miso_msb", miso, exp_tx[DW-1]);
        full_frame("loopback", 8'hA5, 4, 4, -1, 8'h00);

        full_frame("b2b0", 8'h01, 4, 4, -1, 8'h00);
        load_tx(8'h80);
        repeat (2) @(negedge clk);
        check_eq("load80_miso_msb", miso, 1);
        full_frame("b2b1", 8'hFF, 5, 5, -1, 8'h00);

        // Three bits then silence: frame dropped, unsent tx bits survive.
        load_tx(8'hB7);
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        run_frame(8'hE0, 3, 4, -1, 0, -1, 8'h00, got);
        repeat (TO + SS + 8) @(negedge clk);
        check_eq("abort_fe_pulses", fe_cnt - fe0, 1);
        check_eq("abort_rv_pulses", rv_cnt - rv0, 0);
        check_eq("abort_rx_data", rx_data, exp_rx);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_master_bits", got, exp_tx >> (DW - 3));
        exp_tx = exp_tx << 3;
        full_frame("after_abort", 8'h5A, 4, 4, -1, 8'h00);

        load_tx(8'h96);
        full_frame("load_in_shift", 8'h33, 5, 5, 4, 8'hEE);
        load_tx(8'h6B);
        repeat (2) @(negedge clk);
        check_eq("reload_miso_msb", miso, exp_tx[DW-1]);
        full_frame("reload", 8'h4D, 4, 4, -1, 8'h00);

        // Reset in the middle of a frame.
        load_tx(8'hD2);
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        run_frame(8'h9F, 4, 4, -1, 0, -1, 8'h00, got);
        check_eq("midrst_master_bits", got, exp_tx >> (DW - 4));
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_miso", miso, 0);
        check_eq("midrst_tx_ready", tx_ready, 1);
        check_eq("midrst_rx_data", rx_data, 0);
        check_eq("midrst_rx_valid", rx_valid, 0);
        check_eq("midrst_frame_err", frame_err, 0);
        check_eq("midrst_busy", busy, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (TO + 8) @(negedge clk);
        check_eq("midrst_rv_pulses", rv_cnt - rv0, 0);
        check_eq("midrst_fe_pulses", fe_cnt - fe0, 0);
        exp_tx = '0;
        exp_rx = '0;
        full_frame("after_rst", 8'hC3, 4, 4, -1, 8'h00);

        // Rise lands on the last idle cycle before the abort threshold.
        load_tx(8'h5C);
        full_frame("edge_vs_timeout", 8'h2E, 4, TO, -1, 8'h00);

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) load_tx(DW'($urandom));
            w  = DW'($urandom);
            hp = $urandom_range(4, 7);
            full_frame("random", w, hp, $urandom_range(hp, TO), -1, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
SPI slave endpoint that sits directly downstream of the SPI master on the sck/mosi/miso lines. It oversamples sck and mosi in the system clock domain and deserialises one DATA_W-bit word per frame (MSB first), while returning a preloaded word on miso. The bus has no chip select, so frames are delimited by bit count, and an idle timeout re-aligns the receiver.

Parameters:
DATA_W, 8, word width in bits (must equal the master's word width).
SYNC_STAGES, 2, flip-flop stages in the sck/mosi synchronisers (≥2).
TIMEOUT, 32, clk cycles without a synchronised sck edge mid-frame before the partial frame is aborted (≥ 4 × master half-period).

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-low reset.
sck  in  1  serial clock from the master; asynchronous to clk; idle low.
mosi  in  1  serial data from the master.
miso  out  1  serial data to the master.
tx_data  in  DATA_W  word to return in the next frame.
tx_load  in  1  write strobe for tx_data; honoured only when tx_ready=1.
tx_ready  out  1  high in IDLE: tx_load is accepted.
rx_data  out  DATA_W  last completed received word; held until the next completion.
rx_valid  out  1  one-cycle pulse when rx_data updates.
frame_err  out  1  one-cycle pulse on timeout abort.
busy  out  1  high in SHIFT.

Behaviour:
- Reset is asserted while rst=0. It clears every register, including the synchronisers. The outputs then read: miso=0, tx_ready=1, rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE.
- Synchroniser: sck and mosi each pass through SYNC_STAGES flops. One extra flop on the synchronised sck gives the previous value.
  - rise = sync_sck & ~prev_sck
  - fall = ~sync_sck & prev_sck
  - mosi is sampled from its synchronised copy, which carries the same latency as sck, so both stay aligned.
- Input constraint: sck high and low phases must each last ≥2 clk cycles.
- Mode: mosi is sampled on rise. miso shifts on fall. miso always equals tx_shift[DATA_W-1] and is registered.
- IDLE:
  - bit_cnt=0 and idle_cnt=0.
  - tx_load=1 writes tx_data into tx_shift, so miso shows the new MSB on the next cycle.
  - fall is ignored.
  - rise: shift the mosi sample into rx_shift[0], set bit_cnt=1, go to SHIFT. If DATA_W=1, complete immediately, as for the last bit in SHIFT.
- SHIFT:
  - tx_load is ignored and tx_ready=0.
  - rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}, bit_cnt+1, idle_cnt=0.
  - fall: tx_shift <= {tx_shift[DATA_W-2:0], 1'b0}, idle_cnt=0.
  - Neither edge: idle_cnt+1.
  - The rise that makes bit_cnt reach DATA_W completes the frame. In the next cycle rx_data holds the full word, rx_valid=1 for exactly one cycle, tx_shift=0, and state=IDLE.
  - idle_cnt reaching TIMEOUT-1 with no edge aborts the frame. rx_shift and rx_data are unchanged, frame_err pulses one cycle, tx_shift is kept, and state returns to IDLE.
- Simultaneous events: an edge in the same cycle as the timeout threshold wins (no abort). A tx_load in the same cycle as the first rise is ignored, because the frame has started.
- Trailing fall after completion (in IDLE): ignored; miso stays 0 until the next tx_load.
- rst mid-frame: immediate abort to reset values; no rx_valid and no frame_err.
- Latency: rx_valid appears SYNC_STAGES+2 clk cycles after the master's 8th sck rising edge.

Decomposition:
- Shared package spi_pkg: localparams IDLE/SHIFT (2-bit state encoding shared with the master's FSM constants), DEFAULT_DATA_W=8.
- Sub-module spi_sync_edge: N-stage synchroniser plus rise/fall detector. Instantiated once for sck; a plain synchroniser of the same depth is used for mosi.
- The FSM, shift registers and counters stay in the top module.

Test Plan:
1. Loopback with the master (CLK_DIV=2): tx_load 0x3C, master start with data_in 0xA5 -> slave rx_data=0xA5 with one rx_valid pulse; master data_out=0x3C with new_data=1.
2. Back-to-back frames: master sends 0x01 then 0xFF, slave tx_load 0x80 between frames -> rx_valid twice (0x01, 0xFF); master receives 0x00 then 0x80 (tx_shift cleared after frame 1 until reload).
3. Aborted frame: drive 3 sck pulses then hold sck low for TIMEOUT+5 cycles -> frame_err pulses once, rx_data unchanged, busy falls; next full frame 0x5A is received correctly.
4. tx_load during SHIFT with 0xEE -> ignored, tx_ready=0, miso continues the original word; tx_load after rx_valid is accepted.
5. rst=0 asserted after 4 bits of a frame -> all outputs at reset values asynchronously; no rx_valid or frame_err; the subsequent frame 0xC3 is received correctly.
6. Edge/timeout collision: place an sck rise exactly on cycle TIMEOUT-1 of idle -> no frame_err; the frame completes normally.
